// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, funct3 encodings and the decoded op.
// The CSR_COUNTERS_64_EN build macro selects 64-bit counters; it is consumed in csr_file.
package csr_pkg;

  localparam logic [11:0] CSR_TOHOST    = 12'h51E;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  // Register and immediate forms share the same operation.
  function automatic csr_op_e decode_op(input logic [2:0] f3);
    case (f3)
      F3_RW, F3_RWI: decode_op = OP_RW;
      F3_RS, F3_RSI: decode_op = OP_RS;
      F3_RC, F3_RCI: decode_op = OP_RC;
      default:       decode_op = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with 32-bit half writes; a write beats the increment
// and leaves the other half untouched. Widths above 32 expose a writable hi half.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value
);

  generate
    if (CNT_W > 32) begin : g_wide
      // Half writes take priority over counting; lo carries into hi on increment.
      always_ff @(posedge clk) begin
        if (rst)
          value <= '0;
        else if (wr_lo)
          value[31:0] <= wdata;
        else if (wr_hi)
          value[CNT_W-1:32] <= wdata[CNT_W-33:0];
        else if (inc)
          value <= value + CNT_W'(1);
      end
    end else begin : g_narrow
      logic unused_wr_hi;
      assign unused_wr_hi = wr_hi;

      // No hi half exists; only lo writes and increments apply.
      always_ff @(posedge clk) begin
        if (rst)
          value <= '0;
        else if (wr_lo)
          value <= wdata[CNT_W-1:0];
        else if (inc)
          value <= value + CNT_W'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/csr_file.sv
// Machine CSR file: tohost plus mcycle/minstret with read-only user aliases.
// Define CSR_COUNTERS_64_EN for 64-bit counters with hi halves; otherwise
// counters are 32 bits, hi reads return 0 and hi writes are dropped.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] TOHOST_RST = 32'h0,
  parameter int          CNT_W      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic        stall,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        illegal_csr
);

`ifdef CSR_COUNTERS_64_EN
  localparam int CW = CNT_W;
`else
  localparam int CW = 32;
  localparam int unused_cnt_w = CNT_W;
`endif

  csr_op_e       op;
  logic          active;
  logic          wants_write;
  logic [31:0]   operand;
  logic [31:0]   old_val;
  logic [31:0]   wval;
  logic          mapped;
  logic          ro;
  logic          illegal;
  logic          do_write;
  logic [CW-1:0] mcycle;
  logic [CW-1:0] minstret;
  logic [31:0]   mcycle_hi;
  logic [31:0]   minstret_hi;

  assign op          = decode_op(csr_funct3);
  assign active      = csr_en & ~stall & (op != OP_NONE);
  assign operand     = csr_funct3[2] ? {27'b0, rs1_idx} : rs1_data;
  // Set/clear with x0 (or zimm 0) are pure reads.
  assign wants_write = (op == OP_RW) | (rs1_idx != 5'd0);

`ifdef CSR_COUNTERS_64_EN
  assign mcycle_hi   = 32'(mcycle[CW-1:32]);
  assign minstret_hi = 32'(minstret[CW-1:32]);
`else
  assign mcycle_hi   = 32'h0;
  assign minstret_hi = 32'h0;
`endif

  // Read mux and address classification.
  always_comb begin
    old_val = 32'h0;
    mapped  = 1'b1;
    ro      = 1'b0;
    case (csr_addr)
      CSR_TOHOST:    old_val = tohost;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle_hi;
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret_hi;
      CSR_CYCLE:     begin old_val = mcycle[31:0];   ro = 1'b1; end
      CSR_CYCLEH:    begin old_val = mcycle_hi;      ro = 1'b1; end
      CSR_INSTRET:   begin old_val = minstret[31:0]; ro = 1'b1; end
      CSR_INSTRETH:  begin old_val = minstret_hi;    ro = 1'b1; end
      default:       mapped = 1'b0;
    endcase
  end

  // Read-modify-write value.
  always_comb begin
    case (op)
      OP_RS:   wval = old_val | operand;
      OP_RC:   wval = old_val & ~operand;
      default: wval = operand;
    endcase
  end

  assign illegal  = active & (~mapped | (ro & wants_write));
  assign do_write = active & mapped & ~ro & wants_write;

  // tohost register.
  always_ff @(posedge clk) begin
    if (rst)
      tohost <= TOHOST_RST;
    else if (do_write && csr_addr == CSR_TOHOST)
      tohost <= wval;
  end

  // Registered old value for WB and one-cycle illegal pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata   <= 32'h0;
      illegal_csr <= 1'b0;
    end else begin
      illegal_csr <= illegal;
      if (active)
        csr_rdata <= illegal ? 32'h0 : old_val;
    end
  end

  csr_counter #(.CNT_W(CW)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (do_write && csr_addr == CSR_MCYCLE),
    .wr_hi (do_write && csr_addr == CSR_MCYCLEH),
    .wdata (wval),
    .value (mcycle)
  );

  csr_counter #(.CNT_W(CW)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire & ~stall),
    .wr_lo (do_write && csr_addr == CSR_MINSTRET),
    .wr_hi (do_write && csr_addr == CSR_MINSTRETH),
    .wdata (wval),
    .value (minstret)
  );

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter TOHOST_RST, default 32'h0: tohost reset value.
REQ-002 SHALL have parameter CNT_W, default 64: counter width when CSR_COUNTERS_64_EN is defined; forced to 32 otherwise.
REQ-003 SHALL have ports as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- csr_en  input  1  EX-stage instruction is a CSR op.
- csr_funct3  input  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr  input  12  CSR address.
- rs1_idx  input  5  rs1 index; doubles as zimm for the immediate forms.
- rs1_data  input  32  forwarded rs1 value.
- stall  input  1  pipeline stall.
- retire  input  1  a valid instruction leaves EX this cycle.
- csr_rdata  output  32  registered old CSR value, consumed by the WB mux next cycle.
- tohost  output  32  current tohost value.
- illegal_csr  output  1  registered; unmapped address or write to a read-only CSR.

Function
REQ-004 SHALL map: 0x51E tohost (RW); 0xB00/0xB80 mcycle lo/hi (RW); 0xB02/0xB82 minstret lo/hi (RW); 0xC00/0xC80 cycle lo/hi (RO alias); 0xC02/0xC82 instret lo/hi (RO alias).
REQ-005 SHALL treat an op as active only when csr_en=1, stall=0 and funct3 is not 000/100.
REQ-006 SHALL compute the operand as rs1_data for funct3[2]=0, and as {27'b0, rs1_idx} otherwise.
REQ-007 SHALL compute the write value as: RW, operand; RS, old|operand; RC, old&~operand.
REQ-008 SHALL suppress the write for RS/RC/RSI/RCI when rs1_idx=0, with no illegal flag for an RO target.
REQ-009 SHALL, on an active op, update csr_rdata on the same edge with the pre-write value, giving one-cycle latency to WB.
REQ-010 SHALL hold csr_rdata when no op is active.
REQ-011 SHALL set illegal_csr for one cycle, clear csr_rdata to 0 and perform no write on an unmapped address or an actual write to 0xCxx.
REQ-012 SHALL increment mcycle every cycle, including stalled cycles.
REQ-013 SHALL increment minstret when retire=1 and stall=0.
REQ-014 SHALL let a CSR write to a counter half win over that counter's increment in the same cycle.
REQ-015 SHALL leave the other half of the counter unchanged in that cycle.
REQ-016 SHALL wrap counters modulo 2^CNT_W, with carry from the lo half into the hi half.
REQ-017 SHALL return mcycle reads as the value before that cycle's increment.

Reset
REQ-018 SHALL, while rst=1 at a clock edge, set mcycle=0, minstret=0, tohost=TOHOST_RST, csr_rdata=0 and illegal_csr=0.
REQ-019 SHALL ignore csr_en and retire during reset.
REQ-020 SHALL discard an op coincident with reset.
REQ-021 SHALL begin counting on the first edge after rst falls.

Configuration
REQ-022 SHALL, with CSR_COUNTERS_64_EN defined, implement 64-bit counters with readable and writable hi halves.
REQ-023 SHALL, without CSR_COUNTERS_64_EN, implement 32-bit counters.
REQ-024 SHALL, without CSR_COUNTERS_64_EN, return 0 for hi-half reads and ignore hi-half writes without flagging them illegal.

Structure
REQ-025 SHALL place CSR address constants, funct3 encodings and the CSR op enum in shared package csr_pkg.
REQ-026 SHALL implement each counter in sub-module csr_counter, instanced twice for mcycle and minstret.
REQ-027 SHALL give csr_counter these ports: clk, rst, inc, wr_lo, wr_hi, wdata and a value output.
REQ-028 SHALL keep the read mux and illegal decode in csr_file.

Verification
REQ-029 SHALL verify: reset, then 10 idle cycles; CSRRS x0 of 0xC00 -> csr_rdata=10 one cycle later, with no write.
REQ-030 SHALL verify: CSRRW 0x51E with rs1_data=0xDEADBEEF -> csr_rdata=TOHOST_RST and tohost=0xDEADBEEF next cycle; then CSRRCI zimm=0xF -> tohost=0xDEADBEE0.
REQ-031 SHALL verify: CSRRW 0xB00 with rs1_data=5 -> the next cycle-lo read returns 5 plus elapsed cycles, with no lost or extra increment at the write edge.
REQ-032 SHALL verify (64-bit build): mcycle lo=0xFFFFFFFF -> one cycle later lo=0 and hi=+1.
REQ-033 SHALL verify: CSRRW 0xC02 or address 0x123 -> illegal_csr pulses once, csr_rdata=0 and no state changes.
REQ-034 SHALL verify: stall=1 with csr_en=1 and retire=1 for 3 cycles -> no write, csr_rdata held, minstret unchanged, mcycle advances by 3.
